// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - weighted round-robin arbiter with per-requester burst quanta
module weighted_rr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4,
    localparam int IW = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld,
    output logic            grant_last
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);
    localparam logic [WW-1:0] ONE_CNT  = WW'(1);

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  grant_q, grant_d;

    logic          do_arb;
    logic [IW-1:0] arb_ptr;
    logic          arb_found;
    logic [IW-1:0] arb_idx;
    logic [WW-1:0] arb_weight;
    int            k;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        do_arb     = 1'b0;
        arb_ptr    = ptr_q;
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_weight = '0;
        k          = 0;

        if (en) begin
            if (state_q == ST_IDLE) begin
                do_arb = 1'b1;
            end else if (req[owner_q] && (cnt_q > ONE_CNT)) begin
                cnt_d = cnt_q - ONE_CNT;
            end else begin
                // Release: advance past the owner and rearbitrate this same cycle.
                ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + ONE_IDX;
                arb_ptr = ptr_d;
                do_arb  = 1'b1;
            end
        end

        // Scan from the lowest priority upward so the highest-priority hit is kept.
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(arb_ptr) + i) % N;
            if (req[k]) begin
                arb_found = 1'b1;
                arb_idx   = k[IW-1:0];
            end
        end
        arb_weight = weight[int'(arb_idx)*WW +: WW];

        if (do_arb) begin
            if (arb_found) begin
                state_d          = ST_BUSY;
                owner_d          = arb_idx;
                cnt_d            = (arb_weight == '0) ? ONE_CNT : arb_weight;
                grant_d          = '0;
                grant_d[arb_idx] = 1'b1;
            end else begin
                state_d = ST_IDLE;
                owner_d = '0;
                cnt_d   = '0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    assign grant      = grant_q;
    assign grant_idx  = owner_q;
    assign grant_vld  = |grant_q;
    assign grant_last = grant_vld && (cnt_q == ONE_CNT);

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - directed self-checking bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [N*WW-1:0] weight;
    logic [N-1:0]  grant;
    logic [1:0]    grant_idx;
    logic          grant_vld;
    logic          grant_last;

    int n_checks = 0;
    int n_fail   = 0;

    weighted_rr_arbiter #(.N(N), .WW(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .weight     (weight),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld),
        .grant_last (grant_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic el);
        n_checks++;
        assert (grant === eg) else begin
            n_fail++;
            $error("FAIL %s grant: observed %b expected %b", tag, grant, eg);
        end
        n_checks++;
        assert (grant_idx === ei) else begin
            n_fail++;
            $error("FAIL %s grant_idx: observed %0d expected %0d", tag, grant_idx, ei);
        end
        n_checks++;
        assert (grant_vld === (eg != 4'b0)) else begin
            n_fail++;
            $error("FAIL %s grant_vld: observed %b expected %b", tag, grant_vld, (eg != 4'b0));
        end
        n_checks++;
        assert (grant_last === el) else begin
            n_fail++;
            $error("FAIL %s grant_last: observed %b expected %b", tag, grant_last, el);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        req    = '0;
        weight = '0;

        // reset state
        do_reset();
        chk("reset", 4'b0000, 2'd0, 1'b0);

        // idle with no requests
        en = 1'b1;
        tick(); chk("idle0", 4'b0000, 2'd0, 1'b0);
        tick(); chk("idle1", 4'b0000, 2'd0, 1'b0);

        // two requesters, weight 2 each, back-to-back bursts
        do_reset();
        en = 1'b1; req = 4'b1010; weight = 16'h2222;
        tick(); chk("rr_c1", 4'b0010, 2'd1, 1'b0);
        tick(); chk("rr_c2", 4'b0010, 2'd1, 1'b1);
        tick(); chk("rr_c3", 4'b1000, 2'd3, 1'b0);
        tick(); chk("rr_c4", 4'b1000, 2'd3, 1'b1);
        tick(); chk("rr_c5", 4'b0010, 2'd1, 1'b0);

        // single requester re-granted with weight 3
        do_reset();
        en = 1'b1; req = 4'b0001; weight = 16'h0003;
        tick(); chk("solo_c1", 4'b0001, 2'd0, 1'b0);
        tick(); chk("solo_c2", 4'b0001, 2'd0, 1'b0);
        tick(); chk("solo_c3", 4'b0001, 2'd0, 1'b1);
        tick(); chk("solo_c4", 4'b0001, 2'd0, 1'b0);
        tick(); chk("solo_c5", 4'b0001, 2'd0, 1'b0);
        tick(); chk("solo_c6", 4'b0001, 2'd0, 1'b1);

        // owner 2 (weight 5) drops request after two grant cycles
        do_reset();
        en = 1'b1; req = 4'b1100; weight = 16'h2500;
        tick(); chk("drop_c1", 4'b0100, 2'd2, 1'b0);
        tick(); chk("drop_c2", 4'b0100, 2'd2, 1'b0);
        req = 4'b1000;
        #1;     chk("drop_hold", 4'b0100, 2'd2, 1'b0);
        tick(); chk("drop_next", 4'b1000, 2'd3, 1'b0);

        // zero weight means single-cycle bursts
        do_reset();
        en = 1'b1; req = 4'b0010; weight = 16'h0000;
        tick(); chk("w0_c1", 4'b0010, 2'd1, 1'b1);
        tick(); chk("w0_c2", 4'b0010, 2'd1, 1'b1);
        tick(); chk("w0_c3", 4'b0010, 2'd1, 1'b1);

        // enable low mid-burst freezes; weight change does not disturb the burst
        do_reset();
        en = 1'b1; req = 4'b0001; weight = 16'h0005;
        tick(); chk("frz_c1", 4'b0001, 2'd0, 1'b0);
        tick(); chk("frz_c2", 4'b0001, 2'd0, 1'b0);
        en = 1'b0; req = 4'b0010; weight = 16'h0001;
        tick(); chk("frz_off1", 4'b0001, 2'd0, 1'b0);
        tick(); chk("frz_off2", 4'b0001, 2'd0, 1'b0);
        tick(); chk("frz_off3", 4'b0001, 2'd0, 1'b0);
        en = 1'b1; req = 4'b0001;
        tick(); chk("frz_c3", 4'b0001, 2'd0, 1'b0);
        tick(); chk("frz_c4", 4'b0001, 2'd0, 1'b0);
        tick(); chk("frz_c5", 4'b0001, 2'd0, 1'b1);
        tick(); chk("frz_regrant", 4'b0001, 2'd0, 1'b1);

        // reset mid-burst wins over enable; requester 0 favoured afterwards
        do_reset();
        en = 1'b1; req = 4'b1111; weight = 16'h3333;
        tick(); chk("rst_c1", 4'b0001, 2'd0, 1'b0);
        tick(); chk("rst_c2", 4'b0001, 2'd0, 1'b0);
        tick(); chk("rst_c3", 4'b0001, 2'd0, 1'b1);
        tick(); chk("rst_c4", 4'b0010, 2'd1, 1'b0);
        tick(); chk("rst_c5", 4'b0010, 2'd1, 1'b0);
        rst = 1'b1;
        tick(); chk("rst_zero", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick(); chk("rst_first", 4'b0001, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..32.
REQ-002 Parameter WW, default 4, width of each per-requester weight.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port en  input  1  arbiter enable; low freezes all state and outputs.
REQ-006 Port req  input  N  per-requester request level; bit i = requester i.
REQ-007 Port weight  input  N*WW  burst quantum per requester; requester i uses bits [i*WW +: WW].
REQ-008 Port grant  output  N  registered one-hot grant, or all zero.
REQ-009 Port grant_idx  output  max(1,clog2(N))  binary index of the granted requester; 0 when grant is zero.
REQ-010 Port grant_vld  output  1  high when grant is non-zero.
REQ-011 Port grant_last  output  1  high in the final cycle of the current burst (remaining count == 1).

Function
REQ-012 The block SHALL implement two states: IDLE (no owner) and BUSY (one owner, grant[owner]=1).
REQ-013 The block SHALL hold a rotate pointer ptr (0..N-1); the priority order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-014 Arbitration SHALL select the first requester with req set in priority order; with no req set the result is none.
REQ-015 The selected requester SHALL receive a burst of W cycles, with W = weight[winner] sampled in the arbitration cycle; a weight of 0 SHALL be treated as 1.
REQ-016 IDLE, en=1, any req set: at the next edge the block SHALL enter BUSY and set grant to the winner.
REQ-017 IDLE, en=1, no req set: the block SHALL stay in IDLE with grant=0.
REQ-018 The remaining count SHALL load W on grant, so the owner is granted W cycles in total.
REQ-019 BUSY, en=1, req[owner]=1, count>1: the block SHALL hold the grant and decrement count by 1.
REQ-020 BUSY, en=1, count==1 or req[owner]=0: the block SHALL release. Release sets ptr to (owner+1) mod N, wrapping from N-1 to 0.
REQ-021 On release, arbitration SHALL run in the same cycle using the updated ptr.
REQ-022 On release with a winner, the new grant SHALL appear at the next edge with no idle bubble.
REQ-023 On release with no winner, the block SHALL enter IDLE.
REQ-024 On release, if only the previous owner still requests, it SHALL be re-granted with a freshly sampled weight.
REQ-025 grant_last SHALL be combinational from registered state: grant_vld AND count==1.
REQ-026 A drop of req[owner] SHALL NOT retroactively clear grant: grant stays high in that cycle and clears at the next edge.
REQ-027 Changes to weight[owner] during a burst SHALL NOT affect the count in progress.
REQ-028 en=0 SHALL freeze state, ptr, count and outputs, regardless of req.
REQ-029 The count register SHALL be WW bits wide; the maximum burst is 2^WW-1 cycles; no overflow is possible.
REQ-030 grant SHALL never have more than one bit set.
REQ-031 Starvation bound: any requester held high SHALL be granted within (N-1)*(2^WW-1)+1 enabled cycles.

Reset
REQ-032 rst=1 at an edge SHALL force: state IDLE, ptr=0, count=0, grant=0, grant_idx=0, grant_vld=0, grant_last=0.
REQ-033 rst SHALL take priority over en and over an in-progress burst.
REQ-034 The first arbitration after reset SHALL favour requester 0.

Verification (N=4, WW=4)
REQ-035 Reset, then req=4'b1010, all weights 2, en=1. Required: grant 0010 for 2 cycles, then 1000 for 2 cycles, then 0010; no gap; grant_last high on cycles 2 and 4.
REQ-036 req=4'b0001 held, weight0=3. Required: grant 0001 continuously; grant_last pulses every 3rd cycle; ptr cycles 1 and re-grants 0.
REQ-037 Owner 2 with weight 5 drops req after 2 grant cycles while req3=1. Required: grant 0100 for exactly 2 cycles, then 1000 at the next edge.
REQ-038 weight1=0, req=4'b0010. Required: single-cycle bursts with grant_last always high while granted.
REQ-039 en driven low mid-burst for 3 cycles. Required: grant, grant_idx and count unchanged; the burst resumes with the original remaining length.
REQ-040 rst pulsed mid-burst with req=4'b1111. Required: all outputs 0 in the next cycle, then grant 0001 first.
